// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter
//   Shares the single GRF write port among NREQ writers. A round-robin
//   arbiter grants at most one valid requester per cycle (valid/ready
//   handshake), the granted write is registered into a one-stage output
//   register that drives the GRF, and a forwarding tap exposes that pending
//   write to readers before the GRF has captured it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester write request
//   req_addr   requester i destination register at [5*i+4:5*i]
//   req_data   requester i write data at [32*i+31:32*i]
//   req_ready  one-hot (or zero) grant; transfer when valid & ready
//   stall      freezes granting while high
//   regwrite   registered GRF write enable
//   Waddr      registered GRF write address
//   Wdata      registered GRF write data
//   grant_id   index of the requester behind the current output write
//   fwd_ra     read address compared against the pending write
//   fwd_hit    pending write matches fwd_ra (combinational)
//   fwd_data   Wdata when fwd_hit, else 0
module grf_wport_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [5*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                stall,
    output logic                regwrite,
    output logic [4:0]          Waddr,
    output logic [31:0]         Wdata,
    output logic [IDW-1:0]      grant_id,
    input  logic [4:0]          fwd_ra,
    output logic                fwd_hit,
    output logic [31:0]         fwd_data
);

    logic            regwrite_q, regwrite_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            hi_found, lo_found, grant;
    int              hi_idx, lo_idx, win_idx;
    logic [4:0]      sel_addr;
    logic [31:0]     sel_data;

    // Round-robin search split in two halves: the lowest valid index at or
    // above rr_ptr wins; if there is none, the lowest valid index overall
    // (the wrapped part of the search) wins. Scanning downwards leaves the
    // lowest matching index in each result.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 0;
        lo_idx   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = i;
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = i;
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
        // Grants are suppressed while in reset so nobody hands off a write
        // that the output stage is about to discard.
        grant   = (hi_found | lo_found) & ~stall & reset;
    end

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == win_idx) begin
                sel_addr     = req_addr[5*i +: 5];
                sel_data     = req_data[32*i +: 32];
                req_ready[i] = grant;
            end
        end
    end

    // Output stage and pointer update. A ready is only raised towards a
    // valid requester, so grant is the handshake itself.
    always_comb begin
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant) begin
            // $0 writes are accepted and consume a turn but never reach the GRF.
            regwrite_d = (sel_addr != 5'd0);
            waddr_d    = sel_addr;
            wdata_d    = sel_data;
            grant_id_d = IDW'(win_idx);
            rr_ptr_d   = (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign regwrite = regwrite_q;
    assign Waddr    = waddr_q;
    assign Wdata    = wdata_q;
    assign grant_id = grant_id_q;

    // Covers the cycle between output-stage commit and GRF capture.
    assign fwd_hit  = regwrite_q && (waddr_q == fwd_ra) && (fwd_ra != 5'd0);
    assign fwd_data = fwd_hit ? wdata_q : 32'd0;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         stall;
    logic         regwrite;
    logic [4:0]   Waddr;
    logic [31:0]  Wdata;
    logic [1:0]   grant_id;
    logic [4:0]   fwd_ra;
    logic         fwd_hit;
    logic [31:0]  fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    grf_wport_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall     (stall),
        .regwrite  (regwrite),
        .Waddr     (Waddr),
        .Wdata     (Wdata),
        .grant_id  (grant_id),
        .fwd_ra    (fwd_ra),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    // Inputs applied during a row; expected outputs are those visible in that
    // row before its rising edge (registered outputs reflect the previous row).
    typedef struct {
        logic        rst;
        logic        stl;
        logic [3:0]  vld;
        logic [4:0]  a0, a1, a2, a3;
        logic [31:0] db;
        logic [4:0]  fra;
        logic [3:0]  e_rdy;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [1:0]  e_gid;
        logic        e_hit;
        logic [31:0] e_fd;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic rst, logic stl, logic [3:0] vld,
                                logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3,
                                logic [31:0] db, logic [4:0] fra,
                                logic [3:0] e_rdy, logic e_rw, logic [4:0] e_wa,
                                logic [31:0] e_wd, logic [1:0] e_gid,
                                logic e_hit, logic [31:0] e_fd);
        vec_t v;
        v.rst = rst; v.stl = stl; v.vld = vld;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.db = db; v.fra = fra;
        v.e_rdy = e_rdy; v.e_rw = e_rw; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_gid = e_gid; v.e_hit = e_hit; v.e_fd = e_fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic [3:0] vld,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3,
                         input logic [31:0] db, input logic [4:0] fra);
        reset     = rst;
        stall     = stl;
        req_valid = vld;
        req_addr  = {a3, a2, a1, a0};
        req_data  = {db + 32'd3, db + 32'd2, db + 32'd1, db};
        fwd_ra    = fra;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] rdy, input logic rw,
                            input logic [4:0] wa, input logic [31:0] wd,
                            input logic [1:0] gid);
        chk({tag, ".ready"},    32'(req_ready), 32'(rdy));
        chk({tag, ".regwrite"}, 32'(regwrite),  32'(rw));
        chk({tag, ".Waddr"},    32'(Waddr),     32'(wa));
        chk({tag, ".Wdata"},    Wdata,          wd);
        chk({tag, ".grant_id"}, 32'(grant_id),  32'(gid));
    endtask

    initial begin
        //               rst stl vld      a0 a1 a2 a3  db            fra   rdy      rw wa  wd            gid hit fd
        // Reset held with all requesters valid
        tbl[0]  = mk(0, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b0000, 0, 0,  32'h0,        0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b0000, 0, 0,  32'h0,        0, 0, 32'h0);
        // Round-robin, all valid: 0,1,2,3,0
        tbl[2]  = mk(1, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b0001, 0, 0,  32'h0,        0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b0010, 1, 1,  32'h100,      0, 0, 32'h0);
        tbl[4]  = mk(1, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      2,  4'b0100, 1, 2,  32'h101,      1, 1, 32'h101);
        tbl[5]  = mk(1, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b1000, 1, 3,  32'h102,      2, 0, 32'h0);
        tbl[6]  = mk(1, 0, 4'b1111,  1, 2, 3, 4, 32'h100,      0,  4'b0001, 1, 4,  32'h103,      3, 0, 32'h0);
        tbl[7]  = mk(1, 0, 4'b0000,  1, 2, 3, 4, 32'h100,      0,  4'b0000, 1, 1,  32'h100,      0, 0, 32'h0);
        // Single request from requester 1 (ptr is 1)
        tbl[8]  = mk(1, 0, 4'b0010,  0, 5, 0, 0, 32'hDEADBEEE, 0,  4'b0010, 0, 1,  32'h100,      0, 0, 32'h0);
        tbl[9]  = mk(1, 0, 4'b0000,  0, 5, 0, 0, 32'hDEADBEEE, 5,  4'b0000, 1, 5,  32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
        // $0 write from requester 2: accepted, no regwrite, search resumes at 3
        tbl[10] = mk(1, 0, 4'b0100,  0, 0, 0, 0, 32'h1232,     5,  4'b0100, 0, 5,  32'hDEADBEEF, 1, 0, 32'h0);
        tbl[11] = mk(1, 0, 4'b1111,  9, 10, 11, 12, 32'h200,   0,  4'b1000, 0, 0,  32'h1234,     2, 0, 32'h0);
        // Stall with req0/req3 valid; write already in flight still issues
        tbl[12] = mk(1, 1, 4'b1001,  6, 0, 0, 7, 32'h300,      0,  4'b0000, 1, 12, 32'h203,      3, 0, 32'h0);
        tbl[13] = mk(1, 1, 4'b1001,  6, 0, 0, 7, 32'h300,      0,  4'b0000, 0, 12, 32'h203,      3, 0, 32'h0);
        tbl[14] = mk(1, 0, 4'b1001,  6, 0, 0, 7, 32'h300,      0,  4'b0001, 0, 12, 32'h203,      3, 0, 32'h0);
        tbl[15] = mk(1, 0, 4'b1001,  6, 0, 0, 7, 32'h300,      0,  4'b1000, 1, 6,  32'h300,      0, 0, 32'h0);
        // Forwarding of a committed write to addr 7
        tbl[16] = mk(1, 0, 4'b0001,  7, 0, 0, 0, 32'hAA55,     7,  4'b0001, 1, 7,  32'h303,      3, 1, 32'h303);
        tbl[17] = mk(1, 0, 4'b0000,  7, 0, 0, 0, 32'hAA55,     7,  4'b0000, 1, 7,  32'hAA55,     0, 1, 32'hAA55);

        // Establish a known state before the table starts checking
        drive(0, 0, 4'b1111, 1, 2, 3, 4, 32'h100, 0);
        @(negedge clk);

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].stl, tbl[k].vld, tbl[k].a0, tbl[k].a1,
                  tbl[k].a2, tbl[k].a3, tbl[k].db, tbl[k].fra);
            #1;
            chk_outs($sformatf("row%0d", k), tbl[k].e_rdy, tbl[k].e_rw,
                     tbl[k].e_wa, tbl[k].e_wd, tbl[k].e_gid);
            chk($sformatf("row%0d.fwd_hit", k),  32'(fwd_hit), 32'(tbl[k].e_hit));
            chk($sformatf("row%0d.fwd_data", k), fwd_data,     tbl[k].e_fd);
        end

        // Same cycle as row 17 (addr 7 pending): non-matching and $0 read addresses
        fwd_ra = 5'd8;
        #1;
        chk("fwd_ra8.hit",  32'(fwd_hit), 32'd0);
        chk("fwd_ra8.data", fwd_data,     32'd0);
        fwd_ra = 5'd0;
        #1;
        chk("fwd_ra0.hit",  32'(fwd_hit), 32'd0);
        chk("fwd_ra0.data", fwd_data,     32'd0);

        // Reset arriving while a write sits in the output stage (ptr is 1)
        @(negedge clk);
        drive(1, 0, 4'b0010, 0, 3, 0, 0, 32'h54, 0);
        #1;
        chk("mid.grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        drive(0, 0, 4'b1111, 0, 3, 0, 0, 32'h54, 3);
        #1;
        chk_outs("mid.pending", 4'b0000, 1, 3, 32'h55, 1);
        chk("mid.fwd", 32'(fwd_hit), 32'd1);
        @(negedge clk);
        drive(1, 0, 4'b1111, 0, 3, 0, 0, 32'h54, 3);
        #1;
        // Pending write discarded, pointer back at requester 0
        chk_outs("mid.after", 4'b0001, 0, 0, 32'h0, 0);
        chk("mid.fwd_after", 32'(fwd_hit), 32'd0);

        @(negedge clk);
        drive(1, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
